mcu_channel_scheduler: RTL and testbench

Sequences the per-channel entropy-coder outputs (Y, Cb, Cr) into one ordered code-word stream for the compressed-stream stage. It grants channels in strict MCU order: one complete 8x8 block per channel, ending on that channel's end-of-block beat. It also counts MCUs per frame, requests restart markers at a programmable interval, and flags end of frame. It sits between the `ROW` EntropyCoder instances and the stream generator, and owns the channel-to-stream resource.

---
 rtl/mcu_channel_scheduler.sv | 172 +++++++++++++++++
 tb/tb_mcu_channel_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_channel_scheduler.sv
// mcu_channel_scheduler: orders Y/Cb/Cr entropy-coder words into one stream,
// one 8x8 block per channel per MCU, with restart markers and end-of-frame.
module mcu_channel_scheduler #(
  parameter int ROW              = 3,
  parameter int WIDTH            = 1280,
  parameter int HEIGHT           = 720,
  parameter int CODE_W           = 32,
  parameter int RESTART_INTERVAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW-1:0]        in_valid,
  input  logic [ROW*CODE_W-1:0] in_data,
  input  logic [ROW*6-1:0]      in_len,
  input  logic [ROW-1:0]        in_eob,
  output logic [ROW-1:0]        in_ready,
  output logic                  out_valid,
  output logic [CODE_W-1:0]     out_data,
  output logic [5:0]            out_len,
  output logic [1:0]            out_ch,
  input  logic                  out_ready,
  output logic                  rst_marker_req,
  output logic [2:0]            rst_marker_idx,
  input  logic                  rst_marker_ack,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int MCU_TOTAL = (WIDTH / 8) * (HEIGHT / 8);
  localparam int MW = $clog2(MCU_TOTAL + 1);
  localparam int IW = (RESTART_INTERVAL < 1) ? 1
                    : $clog2(RESTART_INTERVAL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_RST,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ch_q, ch_d;
  logic [MW-1:0]       mcu_q, mcu_d, mcu_nxt;
  logic [IW-1:0]       int_q, int_d, int_nxt;
  logic                req_q, req_d;
  logic [2:0]          idx_q, idx_d;
  logic                fd_q, fd_d;
  logic                busy_q, busy_d;
  logic                ov_q, ov_d;
  logic [CODE_W-1:0]   od_q, od_d;
  logic [5:0]          ol_q, ol_d;
  logic [1:0]          oc_q, oc_d;
  logic                can_acc;

  assign out_valid      = ov_q;
  assign out_data       = od_q;
  assign out_len        = ol_q;
  assign out_ch         = oc_q;
  assign rst_marker_req = req_q;
  assign rst_marker_idx = idx_q;
  assign frame_done     = fd_q;
  assign busy           = busy_q;

  // state, counters and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      mcu_q   <= '0;
      int_q   <= '0;
      req_q   <= 1'b0;
      idx_q   <= '0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mcu_q   <= mcu_d;
      int_q   <= int_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      oc_q    <= oc_d;
    end
  end

  // grant, MCU sequencing, marker handshake and output-register load
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mcu_d    = mcu_q;
    int_d    = int_q;
    req_d    = req_q;
    idx_d    = idx_q;
    fd_d     = 1'b0;
    ov_d     = ov_q;
    od_d     = od_q;
    ol_d     = ol_q;
    oc_d     = oc_q;
    in_ready = '0;
    can_acc  = !ov_q || out_ready;
    mcu_nxt  = mcu_q + MW'(1);
    int_nxt  = int_q + IW'(1);

    if (out_ready) ov_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SERVE;
          ch_d    = '0;
          mcu_d   = '0;
          int_d   = '0;
          idx_d   = '0;
        end
      end
      S_SERVE: begin
        in_ready[ch_q] = can_acc;
        if (can_acc && in_valid[ch_q]) begin
          ov_d = 1'b1;
          od_d = in_data[int'(ch_q)*CODE_W +: CODE_W];
          ol_d = in_len[int'(ch_q)*6 +: 6];
          oc_d = ch_q;
          if (in_eob[ch_q]) begin
            if (ch_q == 2'(ROW - 1)) begin
              ch_d  = '0;
              mcu_d = mcu_nxt;
              int_d = int_nxt;
              if (mcu_nxt == MW'(MCU_TOTAL)) begin
                state_d = S_DRAIN;
              end else if (RESTART_INTERVAL != 0 &&
                           int_nxt == IW'(RESTART_INTERVAL)) begin
                state_d = S_RST;
                int_d   = '0;
              end
            end else begin
              ch_d = ch_q + 2'd1;
            end
          end
        end
      end
      S_RST: begin
        if (!req_q && !ov_q) req_d = 1'b1;
        if (req_q && rst_marker_ack) begin
          req_d   = 1'b0;
          idx_d   = idx_q + 3'd1;
          state_d = S_SERVE;
          ch_d    = '0;
        end
      end
      S_DRAIN: begin
        if (!ov_q) begin
          fd_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || fd_d;
  end

endmodule

// File: tb/tb_mcu_channel_scheduler.sv
// tb_mcu_channel_scheduler: directed bench for two configurations,
// 2-MCU frame without markers and 10-MCU frame with a marker every MCU.
module tb_mcu_channel_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, out_ready, rst_marker_ack;
  logic [2:0]  in_valid, in_eob;
  logic [95:0] in_data;
  logic [17:0] in_len;
  logic        sel;

  logic [2:0]  a_ir, b_ir;
  logic        a_ov, b_ov, a_req, b_req, a_fd, b_fd, a_busy, b_busy;
  logic [31:0] a_od, b_od;
  logic [5:0]  a_ol, b_ol;
  logic [1:0]  a_oc, b_oc;
  logic [2:0]  a_idx, b_idx;

  mcu_channel_scheduler #(
    .ROW(3), .WIDTH(16), .HEIGHT(8), .CODE_W(32), .RESTART_INTERVAL(0)
  ) u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .in_valid(in_valid), .in_data(in_data), .in_len(in_len),
    .in_eob(in_eob), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_len(a_ol), .out_ch(a_oc),
    .out_ready(out_ready),
    .rst_marker_req(a_req), .rst_marker_idx(a_idx),
    .rst_marker_ack(rst_marker_ack),
    .frame_done(a_fd), .busy(a_busy)
  );

  mcu_channel_scheduler #(
    .ROW(3), .WIDTH(80), .HEIGHT(8), .CODE_W(32), .RESTART_INTERVAL(1)
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .in_valid(in_valid), .in_data(in_data), .in_len(in_len),
    .in_eob(in_eob), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_len(b_ol), .out_ch(b_oc),
    .out_ready(out_ready),
    .rst_marker_req(b_req), .rst_marker_idx(b_idx),
    .rst_marker_ack(rst_marker_ack),
    .frame_done(b_fd), .busy(b_busy)
  );

  logic [2:0]  ir, oidx;
  logic        ov, oreq, fd, busy;
  logic [31:0] od;
  logic [5:0]  ol;
  logic [1:0]  oc;
  assign ir   = sel ? b_ir   : a_ir;
  assign ov   = sel ? b_ov   : a_ov;
  assign od   = sel ? b_od   : a_od;
  assign ol   = sel ? b_ol   : a_ol;
  assign oc   = sel ? b_oc   : a_oc;
  assign oreq = sel ? b_req  : a_req;
  assign oidx = sel ? b_idx  : a_idx;
  assign fd   = sel ? b_fd   : a_fd;
  assign busy = sel ? b_busy : a_busy;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // source: every channel always valid, beat b of block n carries {ch,n,b}
  int beat [3];
  int blk  [3];
  logic [2:0] fire;
  initial begin
    in_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      beat[c] = 0;
      blk[c]  = 0;
    end
    forever begin
      for (int c = 0; c < 3; c++) begin
        in_data[c*32 +: 32] = {8'h0, 8'(c), 8'(blk[c]), 8'(beat[c])};
        in_len[c*6 +: 6]    = 6'(beat[c] * 3 + c + 1);
        in_eob[c]           = (beat[c] == 2);
      end
      @(negedge clk);
      fire = rst ? 3'b000 : (ir & in_valid);
      @(posedge clk);
      #2;
      for (int c = 0; c < 3; c++) begin
        if (rst) begin
          beat[c] = 0;
          blk[c]  = 0;
        end else if (fire[c]) begin
          if (beat[c] == 2) begin
            beat[c] = 0;
            blk[c]  = blk[c] + 1;
          end else begin
            beat[c] = beat[c] + 1;
          end
        end
      end
    end
  end

  // output monitor: stream order, stall behaviour, frame_done timing
  int k = 0;
  int fd_n = 0;
  int last_cyc = 0;
  int em, ec, eb;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      k          = 0;
      fd_n       = 0;
      stall_prev = 1'b0;
    end else begin
      if (ov && out_ready) begin
        em = k / 9;
        ec = (k % 9) / 3;
        eb = k % 3;
        chk("out_ch", 32'(oc), 32'(ec));
        chk("out_data", od, {8'h0, 8'(ec), 8'(em), 8'(eb)});
        chk("out_len", 32'(ol), 32'(eb * 3 + ec + 1));
        k        = k + 1;
        last_cyc = cyc;
      end
      if (stall_prev) chk("stall_hold", od, prev_d);
      if (ov && !out_ready) chk("stall_no_accept", 32'(ir), 0);
      stall_prev = ov && !out_ready;
      prev_d     = od;
      if (oreq) chk("req_ready_zero", 32'(ir), 0);
      if (ir != 3'b000) chk("ready_onehot", $countones(ir), 1);
      if (fd) begin
        fd_n = fd_n + 1;
        chk("fd_latency", cyc, last_cyc + 2);
      end
    end
  end

  // marker acknowledger: answers three cycles after each request
  int mk;
  initial begin
    rst_marker_ack = 1'b0;
    mk = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        mk = 0;
      end else if (sel && b_req) begin
        chk("marker_idx", 32'(b_idx), 32'(mk % 8));
        chk("marker_after_mcu", k, (mk + 1) * 9);
        mk = mk + 1;
        repeat (3) @(posedge clk);
        #1 rst_marker_ack = 1'b1;
        @(posedge clk);
        #1 rst_marker_ack = 1'b0;
      end
    end
  end

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int i = 0;
    while (fd_n == 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("fd_seen", 32'(fd_n != 0), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ir"},   32'(ir),   0);
    chk({tag, "_ov"},   32'(ov),   0);
    chk({tag, "_od"},   od,        0);
    chk({tag, "_ol"},   32'(ol),   0);
    chk({tag, "_oc"},   32'(oc),   0);
    chk({tag, "_req"},  32'(oreq), 0);
    chk({tag, "_idx"},  32'(oidx), 0);
    chk({tag, "_fd"},   32'(fd),   0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int i;
    rst       = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    out_ready = 1'b1;
    sel       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // plain frame, start-to-grant latency
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    chk("start_grant", 32'(ir), 32'h1);
    chk("busy_on", 32'(busy), 1);
    wait_fd(300);
    chk("t1_words", k, 18);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_fd_once", fd_n, 1);
    chk("busy_off", 32'(busy), 0);

    // five-cycle stall mid-block, with an ignored start
    pulse_rst();
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    i = 0;
    while (k < 4 && i < 100) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("t2_reach", 32'(k >= 4), 1);
    out_ready = 1'b0;
    start_a   = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_fd(300);
    chk("t2_words", k, 18);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_fd_once", fd_n, 1);

    // reset during a channel-1 word, then a clean restart
    pulse_rst();
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    i = 0;
    while (!(ov && oc == 2'd1) && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("t3_reach", 32'(ov && oc == 2'd1), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    chk("t3_grant", 32'(ir), 32'h1);
    wait_fd(300);
    chk("t3_words", k, 18);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_fd_once", fd_n, 1);

    // 10-MCU frame with a marker after every MCU but the last
    @(posedge clk);
    #1 rst = 1'b1;
    sel = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    wait_fd(2000);
    chk("t4_words", k, 90);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_markers", mk, 9);
    chk("t4_idx_final", 32'(oidx), 1);
    chk("t4_fd_once", fd_n, 1);
    chk("t4_req_low", 32'(oreq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
